// File: rtl/bcd_calc_ctrl.sv
// rtl/bcd_calc_ctrl.sv - keypad sequencing controller for the two-digit BCD ALU
module bcd_calc_ctrl #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [1:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_c_out,
    output logic [7:0] disp_value,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_EXEC    = 3'd2,
        S_SHOW    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [1:0] op_q, op_d, chain_op_q, chain_op_d;
    logic       b_entered_q, b_entered_d, is_chain_q, is_chain_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] disp_q, disp_d;
    logic       ovf_q, ovf_d, busy_q, busy_d;

    logic       k_digit, k_op, k_eq, k_clr;
    logic [1:0] key_op;

    assign k_digit = key_valid && (key_code <= 4'd9);
    assign k_op    = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
    assign k_eq    = key_valid && (key_code == 4'hE);
    assign k_clr   = key_valid && (key_code == 4'hC);
    assign key_op  = (key_code == 4'hA) ? 2'b01 : 2'b10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ENTER_A;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            op_q        <= 2'b00;
            chain_op_q  <= 2'b00;
            b_entered_q <= 1'b0;
            is_chain_q  <= 1'b0;
            cnt_q       <= 4'd0;
            disp_q      <= 8'h00;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            chain_op_q  <= chain_op_d;
            b_entered_q <= b_entered_d;
            is_chain_q  <= is_chain_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        chain_op_d  = chain_op_q;
        b_entered_d = b_entered_q;
        is_chain_d  = is_chain_q;
        cnt_d       = cnt_q;
        // Clear wins over everything, including an EXEC completing on the same edge.
        if (k_clr) begin
            state_d     = S_ENTER_A;
            a_d         = 8'h00;
            b_d         = 8'h00;
            op_d        = 2'b00;
            chain_op_d  = 2'b00;
            b_entered_d = 1'b0;
            is_chain_d  = 1'b0;
            cnt_d       = 4'd0;
        end else begin
            case (state_q)
                S_ENTER_A, S_SHOW: begin
                    if (k_digit) begin
                        a_d     = (state_q == S_SHOW) ? {4'h0, key_code} : {a_q[3:0], key_code};
                        state_d = S_ENTER_A;
                    end else if (k_op) begin
                        op_d        = key_op;
                        b_d         = 8'h00;
                        b_entered_d = 1'b0;
                        state_d     = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (k_digit) begin
                        b_d         = {b_q[3:0], key_code};
                        b_entered_d = 1'b1;
                    end else if (k_op && !b_entered_q) begin
                        op_d = key_op;
                    end else if (k_op) begin
                        chain_op_d = key_op;
                        is_chain_d = 1'b1;
                        cnt_d      = 4'd0;
                        state_d    = S_EXEC;
                    end else if (k_eq) begin
                        is_chain_d = 1'b0;
                        cnt_d      = 4'd0;
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == LAST_CNT) begin
                        a_d = alu_result;
                        if (alu_c_out) begin
                            state_d = S_ERR;
                        end else if (is_chain_q) begin
                            op_d        = chain_op_q;
                            b_d         = 8'h00;
                            b_entered_d = 1'b0;
                            state_d     = S_ENTER_B;
                        end else begin
                            state_d = S_SHOW;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_ERR: state_d = S_ERR;
                default: state_d = S_ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp_d = a_d;
        if (state_d == S_ENTER_B) disp_d = b_d;
        else if (state_d == S_EXEC) disp_d = disp_q;
        ovf_d      = (state_d == S_ERR);
        busy_d     = (state_d == S_EXEC);
        alu_opcode = (state_q == S_EXEC) ? op_q : 2'b00;
    end

    assign alu_op1    = a_q;
    assign alu_op2    = b_q;
    assign disp_value = disp_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// tb/tb_bcd_calc_ctrl.sv - self-checking bench for bcd_calc_ctrl
module tb_bcd_calc_ctrl;
    localparam int EC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] alu_op1, alu_op2, alu_result, disp_value;
    logic [1:0] alu_opcode;
    logic       alu_c_out, overflow, busy;

    int total = 0;
    int bad   = 0;

    bcd_calc_ctrl #(.EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_c_out(alu_c_out),
        .disp_value(disp_value), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Behavioural two-digit BCD ALU
    int s_add, s_sub;
    always_comb begin
        s_add = b2i(alu_op1) + b2i(alu_op2);
        s_sub = b2i(alu_op1) - b2i(alu_op2);
        if (alu_opcode == 2'b10) begin
            alu_c_out  = (s_sub < 0);
            alu_result = i2b((s_sub < 0) ? s_sub + 100 : s_sub);
        end else begin
            alu_c_out  = (s_add > 99);
            alu_result = i2b(s_add % 100);
        end
    end

    // Reference model: decimal operands, result computed the instant the op fires
    localparam int M_A = 0, M_B = 1, M_SHOW = 2, M_ERR = 3;
    int ma, mb, mop, mbent, mode;

    task automatic model_reset();
        ma = 0; mb = 0; mop = 0; mbent = 0; mode = M_A;
    endtask

    task automatic model_exec(input int chain_op);
        int r;
        int c;
        if (mop == 2) begin
            c = (ma < mb) ? 1 : 0;
            r = (ma - mb + 100) % 100;
        end else begin
            c = (ma + mb > 99) ? 1 : 0;
            r = (ma + mb) % 100;
        end
        ma = r;
        if (c == 1) mode = M_ERR;
        else if (chain_op != 0) begin
            mop = chain_op; mb = 0; mbent = 0; mode = M_B;
        end else mode = M_SHOW;
    endtask

    task automatic model_key(input logic [3:0] k);
        int d;
        int o;
        d = int'(k);
        o = (k == 4'hA) ? 1 : 2;
        if (k == 4'hC) model_reset();
        else if (mode == M_A || mode == M_SHOW) begin
            if (d <= 9) begin
                ma = (mode == M_SHOW) ? d : (ma % 10) * 10 + d;
                mode = M_A;
            end else if (k == 4'hA || k == 4'hB) begin
                mop = o; mb = 0; mbent = 0; mode = M_B;
            end
        end else if (mode == M_B) begin
            if (d <= 9) begin
                mb = (mb % 10) * 10 + d; mbent = 1;
            end else if ((k == 4'hA || k == 4'hB) && mbent == 0) mop = o;
            else if (k == 4'hA || k == 4'hB) model_exec(o);
            else if (k == 4'hE) model_exec(0);
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_raw(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1; key_code = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic press(input logic [3:0] k);
        press_raw(k);
        wait_idle();
    endtask

    typedef struct {
        string       name;
        logic [39:0] keys;
        int          n;
        logic [7:0]  disp;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        vecs[0]  = '{"add_37_12",      40'h37A12E0000, 6, 8'h49, 1'b0};
        vecs[1]  = '{"sub_99_55",      40'h99B55E0000, 6, 8'h44, 1'b0};
        vecs[2]  = '{"show_digit",     40'h99B55E1000, 7, 8'h01, 1'b0};
        vecs[3]  = '{"add_overflow",   40'h81A81E0000, 6, 8'h62, 1'b1};
        vecs[4]  = '{"err_ignores",    40'h81A81E5E00, 8, 8'h62, 1'b1};
        vecs[5]  = '{"err_clear",      40'h81A81EC000, 7, 8'h00, 1'b0};
        vecs[6]  = '{"chain_shows_b",  40'h15A05B0000, 6, 8'h00, 1'b0};
        vecs[7]  = '{"chain_result",   40'h15A05B20E0, 9, 8'h00, 1'b0};
        vecs[8]  = '{"sub_borrow",     40'h12B34E0000, 6, 8'h78, 1'b1};
        vecs[9]  = '{"third_digit",    40'h1230000000, 3, 8'h23, 1'b0};
        vecs[10] = '{"ignored_df",     40'hDF40000000, 3, 8'h04, 1'b0};
        vecs[11] = '{"op_replace",     40'h5AB3E00000, 5, 8'h02, 1'b0};
        vecs[12] = '{"eq_no_b",        40'h5AE0000000, 3, 8'h05, 1'b0};
        vecs[13] = '{"show_op_chain",  40'h2A3EA4E000, 7, 8'h09, 1'b0};

        do_reset();
        check("reset_disp", disp_value, 0);
        check("reset_ovf", overflow, 0);
        check("reset_busy", busy, 0);
        check("reset_opcode", alu_opcode, 0);
        check("reset_op1", alu_op1, 0);

        for (int i = 0; i < 14; i++) begin
            logic [39:0] ks;
            do_reset();
            ks = vecs[i].keys;
            for (int j = 0; j < vecs[i].n; j++) press(ks[39 - 4*j -: 4]);
            check({vecs[i].name, "_disp"}, disp_value, vecs[i].disp);
            check({vecs[i].name, "_ovf"}, overflow, vecs[i].ovf);
        end

        // Operands and opcode held on the ALU for exactly EC cycles
        do_reset();
        press(4'h3); press(4'h7); press(4'hA); press(4'h1); press(4'h2);
        press_raw(4'hE);
        for (int i = 0; i < EC; i++) begin
            check("exec_busy", busy, 1);
            check("exec_op1", alu_op1, 8'h37);
            check("exec_op2", alu_op2, 8'h12);
            check("exec_opcode", alu_opcode, 2'b01);
            @(negedge clk);
        end
        check("exec_done_busy", busy, 0);
        check("exec_done_opcode", alu_opcode, 0);
        check("exec_done_disp", disp_value, 8'h49);

        // Digit pulsed while busy is dropped
        do_reset();
        press(4'h1); press(4'hA); press(4'h2);
        press_raw(4'hE);
        press_raw(4'h7);
        wait_idle();
        check("drop_disp", disp_value, 8'h03);
        press(4'hA);
        check("drop_show_op", disp_value, 8'h00);
        press(4'hE);
        check("drop_result", disp_value, 8'h03);

        // Reset in the middle of EXEC
        do_reset();
        press(4'h4); press(4'hA); press(4'h5);
        press_raw(4'hE);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_exec_busy", busy, 0);
        check("rst_exec_disp", disp_value, 0);
        check("rst_exec_op1", alu_op1, 0);
        check("rst_exec_op2", alu_op2, 0);
        check("rst_exec_opcode", alu_opcode, 0);

        // C mid-EXEC, then C on the completing edge
        do_reset();
        press(4'h4); press(4'hA); press(4'h5);
        press_raw(4'hE);
        press_raw(4'hC);
        check("clr_exec_busy", busy, 0);
        check("clr_exec_op1", alu_op1, 0);
        check("clr_exec_disp", disp_value, 0);
        press(4'h6);
        check("clr_exec_enter_a", disp_value, 8'h06);
        do_reset();
        press(4'h9); press(4'hA); press(4'h9); press(4'h9);
        press_raw(4'hE);
        @(negedge clk);
        press_raw(4'hC);
        check("clr_last_ovf", overflow, 0);
        check("clr_last_op1", alu_op1, 0);
        check("clr_last_disp", disp_value, 0);

        // Randomised keys against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] k;
            int r;
            r = int'($urandom_range(99));
            if (mode == M_ERR && r < 30) k = 4'hC;
            else if (r < 55) k = 4'($urandom_range(9));
            else if (r < 75) k = ($urandom_range(1) == 0) ? 4'hA : 4'hB;
            else if (r < 88) k = 4'hE;
            else if (r < 92) k = 4'hC;
            else k = ($urandom_range(1) == 0) ? 4'hD : 4'hF;
            press_raw(k);
            model_key(k);
            if (busy && $urandom_range(3) == 0) press_raw(4'($urandom_range(9)));
            wait_idle();
            check("rand_disp", disp_value, (mode == M_B) ? i2b(mb) : i2b(ma));
            check("rand_ovf", overflow, (mode == M_ERR) ? 1 : 0);
            check("rand_op1", alu_op1, i2b(ma));
            check("rand_op2", alu_op2, i2b(mb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_calc_ctrl.md
# bcd_calc_ctrl

Sequencing controller for the two-digit BCD ALU, `alu`, in the calculator datapath. It takes debounced keypad codes, assembles two 2-digit BCD operands and applies them with the pending opcode to `alu` for a fixed number of cycles. It then captures the result and carry/borrow, and drives the display value and the overflow indicator. Operations can be chained; each result becomes the next first operand.

## Interface
Parameters:
- `EXEC_CYCLES`, default 1: cycles operands and opcode are held on `alu` before the result is captured. Legal range 1..15.

Ports:
- `clk`  in  1: system clock. Everything updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: one-cycle strobe; `key_code` is valid when this is high.
- `key_code`  in  4: 0-9 digit, A add, B subtract, C clear, E equals; D and F are ignored.
- `alu_op1`  out  8: BCD first operand to `alu` (register A).
- `alu_op2`  out  8: BCD second operand to `alu` (register B).
- `alu_opcode`  out  2: 00 idle, 01 add, 10 subtract.
- `alu_result`  in  8: BCD result from `alu`, combinational.
- `alu_c_out`  in  1: `alu` MSD carry-out on add, borrow on subtract.
- `disp_value`  out  8: BCD value shown on the 2-digit display.
- `overflow`  out  1: high while in ERR.
- `busy`  out  1: high while in EXEC.

## Operation
- Registers:
  - A and B, 8-bit BCD each.
  - `op`, 2 bits: pending operation.
  - `chain_op`, 2 bits: operation held while an execution runs.
  - `b_entered` flag and `is_chain` flag.
  - Cycle counter, 4 bits.
- Outputs:
  - `alu_op1` = A and `alu_op2` = B at all times.
  - `alu_opcode` = `op` in EXEC only, else 00.
- Digit entry shifts the register: X <= {X[3:0], digit}. A third digit discards the oldest one. No range check is needed because codes 0-9 are BCD by construction.
- States:
  - ENTER_A (reset state), display = A.
    - Digit: shift into A.
    - A or B key: `op` <= 01 or 10, B <= 00, `b_entered` <= 0, go to ENTER_B.
    - E: ignored.
  - ENTER_B, display = B.
    - Digit: shift into B, `b_entered` <= 1.
    - Operator with `b_entered` = 0: replace `op` and stay.
    - Operator with `b_entered` = 1: `chain_op` <= new op, `is_chain` <= 1, go to EXEC.
    - E: `is_chain` <= 0, go to EXEC. B = 00 is used if no digit was entered.
  - EXEC, `busy` = 1.
    - Counter runs 0..`EXEC_CYCLES`-1. On the last cycle, A <= `alu_result`.
    - If `alu_c_out` = 1, go to ERR.
    - Otherwise, if `is_chain` = 1: `op` <= `chain_op`, B <= 00, `b_entered` <= 0, go to ENTER_B.
    - Otherwise go to SHOW.
    - All keys except C are dropped, not queued.
  - SHOW, display = A.
    - Digit: A <= {4'h0, digit}, go to ENTER_A.
    - Operator: same action as the operator key in ENTER_A, with A kept as the first operand.
    - E: ignored.
  - ERR, display = A (the raw captured result), `overflow` = 1. Only C or `rst` leaves this state.
- C in any state, EXEC included (it aborts EXEC): A = B = 00, `op` = 00, flags cleared, go to ENTER_A.
- Reset values:
  - State ENTER_A; A, B, `op`, `chain_op` = 00; counter = 0.
  - `disp_value` = 00, `alu_opcode` = 00, `overflow` = 0, `busy` = 0.

## Timing
- A key is accepted on the rising edge where `key_valid` = 1.
- `disp_value`, `overflow` and `busy` are registered. They reflect an accepted key from the next cycle on.
- An E or chaining operator accepted at edge N gives:
  - `busy` = 1 and `alu_opcode` ≠ 00 during cycles N+1 .. N+`EXEC_CYCLES`.
  - Result captured at edge N+`EXEC_CYCLES`.
  - New `disp_value` and `overflow` visible from the following cycle.
- `alu` is combinational. Operands are stable for the whole of EXEC because A and B do not change during EXEC.
- `rst` has priority over everything, including a simultaneous `key_valid`. Reset during EXEC discards the operation; outputs show reset values from the next cycle.
- C has priority over the EXEC completion when both fall on the same edge.

## Test plan
- Keys 3,7,A,1,2,E:
  - During EXEC: `alu_op1` = 37, `alu_op2` = 12, `alu_opcode` = 01 for `EXEC_CYCLES` cycles.
  - Then `disp_value` = 49, `overflow` = 0, state SHOW.
- Keys 9,9,B,5,5,E:
  - During EXEC: `alu_opcode` = 10.
  - Then `disp_value` = 44.
  - Next key 1: `disp_value` = 01, state ENTER_A.
- Keys 8,1,A,8,1,E:
  - `alu_c_out` = 1, so `overflow` = 1 and `disp_value` = 62.
  - Digit 5 and E are ignored.
  - C gives `disp_value` = 00, `overflow` = 0.
- Chaining, keys 1,5,A,0,5,B,2,0,E:
  - B key executes 15+05; `disp_value` shows B = 00 with `op` = 10.
  - Final `disp_value` = 00 from 20-20, `overflow` = 0.
- Subtract with borrow, keys 1,2,B,3,4,E: `overflow` = 1, state ERR.
- Boundary cases, with `EXEC_CYCLES` = 3:
  - Keys 1,2,3: `disp_value` = 23.
  - A digit pulsed while `busy` = 1 is dropped.
  - `rst` asserted mid-EXEC: all reset values on the next cycle.
  - C during EXEC: A = 00, state ENTER_A.
